// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - packs a byte stream MSB-first into 32-bit words
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic        word_full,
    output logic [31:0] packed_word
);

    logic [23:0] hold;
    logic [1:0]  cnt;

    // The 4th byte is presented combinationally so the word is complete in the accepting cycle.
    assign packed_word = {hold, byte_in};
    assign word_full   = shift && (cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            hold <= '0;
            cnt  <= '0;
        end else if (shift) begin
            hold <= {hold[15:0], byte_in};
            cnt  <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a checksummed byte frame into instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        error
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    state_t             state;
    state_t             state_next;
    logic [7:0]         len_hi;
    logic [CNT_W-1:0]   n_words;
    logic [CNT_W-1:0]   len_full;
    logic [IDX_W-1:0]   word_idx;
    logic [7:0]         xor_acc;
    logic               accept;
    logic               rearm;
    logic               shift;
    logic               word_full;
    logic               last_word;
    logic [31:0]        packed_word;

    // Reset gates ready so no byte can be claimed during the reset cycle.
    assign byte_ready = reset && (state == LEN_HI || state == LEN_LO ||
                                  state == DATA   || state == CHECK);
    assign accept     = byte_valid && byte_ready;
    assign rearm      = start && (state == DONE || state == ERR);
    assign shift      = accept && (state == DATA);
    assign len_full   = CNT_W'({len_hi, byte_data});
    assign last_word  = (32'(word_idx) + 32'd1) == 32'(n_words);

    byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (rearm),
        .shift       (shift),
        .byte_in     (byte_data),
        .word_full   (word_full),
        .packed_word (packed_word)
    );

    always_comb begin
        state_next = state;
        case (state)
            LEN_HI: if (accept) state_next = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (len_full == '0 || 32'(len_full) > MAX_WORDS)
                        state_next = ERR;
                    else
                        state_next = DATA;
                end
            end
            DATA:   if (word_full && last_word) state_next = CHECK;
            CHECK:  if (accept) state_next = (byte_data == xor_acc) ? DONE : ERR;
            DONE:   if (start) state_next = LEN_HI;
            ERR:    if (start) state_next = LEN_HI;
            default: state_next = LEN_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= LEN_HI;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            len_hi     <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            xor_acc    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            // Status flags follow the state being entered, so they move on the deciding edge.
            done      <= (state_next == DONE);
            error     <= (state_next == ERR);
            cpu_rst_n <= (state_next == DONE);

            if (rearm) begin
                word_idx <= '0;
                xor_acc  <= '0;
            end
            if (accept && state == LEN_HI) len_hi  <= byte_data;
            if (accept && state == LEN_LO) n_words <= len_full;
            if (shift) xor_acc <= xor_acc ^ byte_data;
            if (word_full) begin
                imem_we    <= 1'b1;
                imem_addr  <= 32'({word_idx, 2'b00});
                imem_wdata <= packed_word;
                word_idx   <= word_idx + 1'b1;
            end
        end
    end

endmodule
